// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending scoreboard.
// Reads are combinational with same-cycle writeback bypass; x0 is hardwired to zero.
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int RPORTS = 2,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RPORTS-1:0]      rd_en_i,
  input  logic [RPORTS*AW-1:0]   rd_addr_i,
  output logic [RPORTS*XLEN-1:0] rd_data_o,
  output logic [RPORTS-1:0]      rd_busy_o,
  input  logic                   wb_en_i,
  input  logic [AW-1:0]          wb_addr_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i,
  input  logic                   flush_i,
  output logic [AW:0]            pend_cnt_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [AW:0]     cnt_next;
  logic            wb_valid;
  logic            iss_valid;

  assign wb_valid  = wb_en_i && (wb_addr_i != '0);
  assign iss_valid = iss_en_i && (iss_addr_i != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Issue is applied after writeback so a same-cycle issue wins (new producer).
  always_comb begin
    pend_next = pend;
    if (flush_i) begin
      pend_next = '0;
    end else begin
      if (wb_valid) begin
        pend_next[wb_addr_i] = 1'b0;
      end
      if (iss_valid) begin
        pend_next[iss_addr_i] = 1'b1;
      end
    end
    pend_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + (AW+1)'(pend_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= '0;
      pend_cnt_o <= '0;
    end else begin
      pend       <= pend_next;
      pend_cnt_o <= cnt_next;
    end
  end

  // Reset gating keeps the bypass path from leaking writeback data during reset.
  for (genvar p = 0; p < RPORTS; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          act;
    logic          hit;

    assign addr = rd_addr_i[p*AW +: AW];
    assign act  = rst && rd_en_i[p] && (addr != '0);
    assign hit  = wb_en_i && (wb_addr_i == addr);

    assign rd_data_o[p*XLEN +: XLEN] = !act ? '0 : (hit ? wb_data_i : regs[addr]);
    assign rd_busy_o[p]              = act && !hit && pend[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued as stimulus is driven
// and popped in order as DUT outputs are sampled.
module tb_regfile_sb;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RPORTS = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [RPORTS-1:0]      rd_en;
  logic [RPORTS*AW-1:0]   rd_addr;
  logic [RPORTS*XLEN-1:0] rd_data;
  logic [RPORTS-1:0]      rd_busy;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   flush;
  logic [AW:0]            pend_cnt;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .RPORTS(RPORTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wb_en_i    (wb_en),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .flush_i    (flush),
    .pend_cnt_o (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_val(input string tag, input logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [XLEN-1:0] observed);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed %0h required <queued entry>", observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h required %0h", e.tag, observed, e.exp);
    end
  endtask

  // Queue data and busy expectations for one port.
  task automatic expect_port(input string tag, input logic [XLEN-1:0] d, input logic b);
    expect_val({tag, "_data"}, d);
    expect_val({tag, "_busy"}, XLEN'(b));
  endtask

  task automatic sample_port(input int p);
    check_output(rd_data[p*XLEN +: XLEN]);
    check_output(XLEN'(rd_busy[p]));
  endtask

  task automatic sample_cnt();
    check_output(XLEN'(pend_cnt));
  endtask

  task automatic set_read(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p]            = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                input logic ie, input logic [AW-1:0] ia, input logic fl);
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);

    // Reset state, including a writeback that must not bypass while in reset
    set_read(0, 1'b1, 5'd5);
    apply_stimulus(1'b1, 5'd5, 32'hCAFE_F00D, 1'b0, '0, 1'b0);
    expect_val("reset_cnt", '0);
    expect_port("reset_p0", '0, 1'b0);
    #2;
    sample_cnt();
    sample_port(0);
    tick();
    tick();
    rst = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    expect_port("post_reset_x5", '0, 1'b0);
    #1;
    sample_port(0);

    // Writeback then read from storage; x0 reads zero
    apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd5);
    set_read(1, 1'b1, 5'd0);
    expect_port("x5_p0", 32'hDEAD_BEEF, 1'b0);
    expect_port("x0_p1", '0, 1'b0);
    #1;
    sample_port(0);
    sample_port(1);

    // Same-cycle bypass on port 1, then the stored value next cycle
    set_read(1, 1'b1, 5'd7);
    apply_stimulus(1'b1, 5'd7, 32'h0000_1234, 1'b0, '0, 1'b0);
    expect_port("bypass_x7_p1", 32'h0000_1234, 1'b0);
    #1;
    sample_port(1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    expect_port("stored_x7_p1", 32'h0000_1234, 1'b0);
    #1;
    sample_port(1);

    // Disabled port drives zero; writeback to x0 neither bypasses nor stores
    set_read(1, 1'b0, 5'd7);
    set_read(0, 1'b1, 5'd0);
    apply_stimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
    expect_port("disabled_p1", '0, 1'b0);
    expect_port("bypass_x0_p0", '0, 1'b0);
    #1;
    sample_port(1);
    sample_port(0);
    tick();

    // Issue x3 and x4, check busy on both ports and the count
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd3);
    set_read(1, 1'b1, 5'd3);
    expect_val("cnt_two", 32'd2);
    expect_port("x3_pend_p0", '0, 1'b1);
    expect_port("x3_pend_p1", '0, 1'b1);
    #1;
    sample_cnt();
    sample_port(0);
    sample_port(1);

    // Writeback x3 clears its pend bit; x4 stays pending
    apply_stimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, '0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(1, 1'b1, 5'd4);
    expect_val("cnt_after_wb", 32'd1);
    expect_port("x3_done_p0", 32'h0000_0033, 1'b0);
    expect_port("x4_pend_p1", '0, 1'b1);
    #1;
    sample_cnt();
    sample_port(0);
    sample_port(1);

    // Reissue of a pending register does not count twice
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    expect_val("cnt_reissue", 32'd1);
    #1;
    sample_cnt();
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    expect_val("cnt_flushed", 32'd0);
    #1;
    sample_cnt();

    // Issue and writeback to the same register in one cycle
    apply_stimulus(1'b1, 5'd9, 32'h0000_0055, 1'b1, 5'd9, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd9);
    expect_val("cnt_iss_wb", 32'd1);
    expect_port("x9_iss_wb_p0", 32'h0000_0055, 1'b1);
    #1;
    sample_cnt();
    sample_port(0);

    // Fill the scoreboard to its maximum, then flush with issue+writeback to x2
    for (int r = 1; r < NREG; r++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, AW'(r), 1'b0);
      tick();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    expect_val("cnt_full", 32'd31);
    #1;
    sample_cnt();
    apply_stimulus(1'b1, 5'd2, 32'h0000_000A, 1'b1, 5'd2, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd2);
    expect_val("cnt_flush_all", 32'd0);
    expect_port("x2_after_flush", 32'h0000_000A, 1'b0);
    #1;
    sample_cnt();
    sample_port(0);

    // Mid-cycle reset clears state immediately and discards an in-flight write
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd6, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd6);
    set_read(1, 1'b1, 5'd5);
    expect_val("cnt_x6", 32'd1);
    #1;
    sample_cnt();
    #1;
    apply_stimulus(1'b1, 5'd5, 32'h1111_2222, 1'b0, '0, 1'b0);
    rst = 1'b0;
    expect_val("cnt_async_reset", '0);
    expect_port("x6_async_reset", '0, 1'b0);
    expect_port("x5_async_reset", '0, 1'b0);
    #1;
    sample_cnt();
    sample_port(0);
    sample_port(1);
    tick();
    rst = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    expect_port("x5_discarded", '0, 1'b0);
    #1;
    sample_port(1);

    // First edge after reset release operates normally
    apply_stimulus(1'b1, 5'd8, 32'h0000_0077, 1'b1, 5'd10, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    set_read(0, 1'b1, 5'd8);
    set_read(1, 1'b1, 5'd10);
    expect_val("cnt_after_reset", 32'd1);
    expect_port("x8_after_reset", 32'h0000_0077, 1'b0);
    expect_port("x10_after_reset", '0, 1'b1);
    #1;
    sample_cnt();
    sample_port(0);
    sample_port(1);

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of each register and of each data port.
REQ-002 Parameter NREG, default 32: number of architectural registers, a power of two of at least 2; AW = log2(NREG).
REQ-003 Parameter RPORTS, default 2: number of independent read ports, at least 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rd_en_i  input  RPORTS  per-port read enable.
REQ-007 rd_addr_i  input  RPORTS*AW  per-port read address; port p occupies bits [p*AW +: AW].
REQ-008 rd_data_o  output  RPORTS*XLEN  per-port read data (combinational); port p occupies bits [p*XLEN +: XLEN].
REQ-009 rd_busy_o  output  RPORTS  per-port flag: the source register has an outstanding producer.
REQ-010 wb_en_i  input  1  writeback enable.
REQ-011 wb_addr_i  input  AW  writeback destination.
REQ-012 wb_data_i  input  XLEN  writeback data.
REQ-013 iss_en_i  input  1  issue enable: marks a destination as pending.
REQ-014 iss_addr_i  input  AW  destination register being issued.
REQ-015 flush_i  input  1  clears all pending marks.
REQ-016 pend_cnt_o  output  AW+1  registered count of pending registers.

Function
REQ-017 Register file SHALL hold NREG x XLEN storage; register 0 always reads 0 and ignores writes.
REQ-018 Writeback SHALL be sequential: on a clk edge with wb_en_i=1 and wb_addr_i!=0, regs[wb_addr_i] <= wb_data_i; the new value is visible from storage in the following cycle.
REQ-019 Read port p with rd_en_i[p]=0 SHALL drive data 0 and busy 0.
REQ-020 Read port p with address 0 SHALL drive data 0 and busy 0.
REQ-021 Bypass: with wb_en_i=1 and wb_addr_i equal to a nonzero read address, the port SHALL drive wb_data_i in the same cycle and busy 0.
REQ-022 Otherwise the port SHALL drive regs[addr] and busy = pend[addr].
REQ-023 Scoreboard: one pending bit per register; pend[0] is constant 0.
REQ-024 Each clk edge, in priority order: flush_i=1 clears every pend bit; else iss_en_i=1 with iss_addr_i!=0 sets pend[iss_addr_i]; wb_en_i=1 with wb_addr_i!=0 clears pend[wb_addr_i] unless that address is set by issue in the same cycle.
REQ-025 Issue and writeback to the same address in the same cycle SHALL leave the bit set (a new producer); the data write still occurs.
REQ-026 flush_i SHALL NOT suppress a same-cycle data writeback; an issue in a flush cycle is discarded.
REQ-027 Reissue to an already-pending register SHALL leave it pending (single bit, no counting).
REQ-028 pend_cnt_o SHALL equal the population count of the pend bits after each edge update (range 0..NREG-1); zero-latency relative to the pend state.
REQ-029 Multiple read ports reading the same address SHALL return identical data and busy.

Reset
REQ-030 While rst=0, all registers SHALL be 0, all pend bits 0, and pend_cnt_o 0, asynchronously; all rd_data_o and rd_busy_o SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending and in-flight writes; the first edge after rst rises SHALL operate normally.

Verification
REQ-032 Reset, then wb x5=0xDEADBEEF; next cycle read x5 on port 0 -> 0xDEADBEEF, busy 0; read x0 -> 0.
REQ-033 wb x7=0x1234 while port 1 reads x7 in the same cycle -> port 1 = 0x1234, busy 0 (bypass).
REQ-034 Issue x3, x4; next cycle read x3 -> busy 1, pend_cnt_o=2; wb x3 -> next cycle pend_cnt_o=1, x3 busy 0.
REQ-035 Issue x9 and wb x9=0x55 in the same cycle -> next cycle x9 reads 0x55, busy 1, pend_cnt_o=1.
REQ-036 Pend x1..x31, then flush with simultaneous issue x2 and wb x2=0xA -> pend_cnt_o=0, x2 reads 0xA, busy 0.
REQ-037 Issue x6, then assert rst=0 between clk edges -> pend_cnt_o and every register read as 0 immediately.
